// File: rtl/alu_issue_if.sv
// alu_issue_if: issue-stage handshake, register-file read, output and writeback signals
interface alu_issue_if;
  logic flush;
  logic in_valid;
  logic in_ready;
  logic [31:0] in_instr;
  logic [31:0] in_pc;
  logic [4:0] rf_rs1_addr;
  logic [4:0] rf_rs2_addr;
  logic [31:0] rf_rs1_data;
  logic [31:0] rf_rs2_data;
  logic out_valid;
  logic out_ready;
  logic [2:0] alu_opcode;
  logic [31:0] op_0;
  logic [31:0] op_1;
  logic [4:0] rd;
  logic rd_we;
  logic illegal;
  logic wb_valid;
  logic [4:0] wb_rd;
  modport slave (
    input flush, in_valid, in_instr, in_pc, rf_rs1_data, rf_rs2_data, out_ready, wb_valid, wb_rd,
    output in_ready, rf_rs1_addr, rf_rs2_addr, out_valid, alu_opcode, op_0, op_1, rd, rd_we, illegal
  );
  modport master (
    output flush, in_valid, in_instr, in_pc, rf_rs1_data, rf_rs2_data, out_ready, wb_valid, wb_rd,
    input in_ready, rf_rs1_addr, rf_rs2_addr, out_valid, alu_opcode, op_0, op_1, rd, rd_we, illegal
  );
endinterface

// File: rtl/alu_issue_stage.sv
// alu_issue_stage: RV32I ALU-subset decode, operand select and issue with pending-write scoreboard
module alu_issue_stage (
  input logic clk,
  input logic rst,
  alu_issue_if.slave bus
);
  localparam logic [6:0] opc_op = 7'b0110011, opc_imm = 7'b0010011, opc_lui = 7'b0110111, opc_auipc = 7'b0010111;
  localparam logic [6:0] f7_alt = 7'b0100000;
  localparam logic [2:0] a_add = 3'b000, a_sub = 3'b001, a_and = 3'b010, a_or = 3'b011, a_xor = 3'b100, a_sll = 3'b101, a_srl = 3'b110, a_sra = 3'b111;
  logic [6:0] opc, f7;
  logic [2:0] f3, base, code;
  logic [4:0] rs1, rs2, rd_a;
  logic is_op, is_imm, is_lui, is_auipc, is_sh, slt, alt, ill, we, use1, use2, hazard, accept;
  logic [31:0] v0, v1, pend, clr, set;
  assign opc = bus.in_instr[6:0];
  assign f3 = bus.in_instr[14:12];
  assign f7 = bus.in_instr[31:25];
  assign rs1 = bus.in_instr[19:15];
  assign rs2 = bus.in_instr[24:20];
  assign rd_a = bus.in_instr[11:7];
  assign bus.rf_rs1_addr = rs1;
  assign bus.rf_rs2_addr = rs2;
  always_comb begin
    is_op = opc == opc_op;
    is_imm = opc == opc_imm;
    is_lui = opc == opc_lui;
    is_auipc = opc == opc_auipc;
    is_sh = f3[1:0] == 2'b01;
    slt = f3[2:1] == 2'b01;
    ill = !(is_op || is_imm || is_lui || is_auipc)
      || (is_op && (slt || !(f7 == 7'b0 || (f7 == f7_alt && (f3 == 3'b000 || f3 == 3'b101)))))
      || (is_imm && (slt || (is_sh && !(f7 == 7'b0 || f7 == f7_alt))));
    alt = f7 == f7_alt && (is_op || (is_imm && f3 == 3'b101));
    base = f3 == 3'b000 ? a_add : f3 == 3'b001 ? a_sll : f3 == 3'b100 ? a_xor :
           f3 == 3'b101 ? a_srl : f3 == 3'b110 ? a_or : a_and;
    code = (ill || is_lui || is_auipc) ? a_add : alt ? (f3 == 3'b000 ? a_sub : a_sra) : base;
    v0 = (ill || is_lui) ? 32'b0 : is_auipc ? bus.in_pc : bus.rf_rs1_data;
    v1 = ill ? 32'b0 : is_op ? bus.rf_rs2_data :
         is_imm ? (is_sh ? {27'b0, rs2} : {{20{bus.in_instr[31]}}, bus.in_instr[31:20]}) :
         {bus.in_instr[31:12], 12'b0};
    we = !ill && rd_a != 5'd0;
    use1 = !ill && (is_op || is_imm);
    use2 = !ill && is_op;
    hazard = (use1 && pend[rs1]) || (use2 && pend[rs2]) || (we && pend[rd_a]);
    bus.in_ready = !rst && !bus.flush && !hazard && (!bus.out_valid || bus.out_ready);
    accept = bus.in_valid && bus.in_ready;
    // clears applied before sets so a same-cycle set of one register wins
    clr = (bus.wb_valid ? 32'b1 << bus.wb_rd : 32'b0)
        | ((bus.flush && bus.out_valid && bus.rd_we) ? 32'b1 << bus.rd : 32'b0);
    set = (accept && we) ? 32'b1 << rd_a : 32'b0;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      pend <= '0;
      bus.out_valid <= 1'b0;
      bus.alu_opcode <= a_add;
      bus.op_0 <= '0;
      bus.op_1 <= '0;
      bus.rd <= '0;
      bus.rd_we <= 1'b0;
      bus.illegal <= 1'b0;
    end else begin
      pend <= ((pend & ~clr) | set) & 32'hffff_fffe;
      if (bus.flush) bus.out_valid <= 1'b0;
      else if (accept) begin
        bus.out_valid <= 1'b1;
        bus.alu_opcode <= code;
        bus.op_0 <= v0;
        bus.op_1 <= v1;
        bus.rd <= rd_a;
        bus.rd_we <= we;
        bus.illegal <= ill;
      end else if (bus.out_ready) bus.out_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_alu_issue_stage.sv
// tb_alu_issue_stage: directed vectors with hand-computed expectations for alu_issue_stage
module tb_alu_issue_stage;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int n_cmp = 0;
  int n_err = 0;
  logic [31:0] rf [32];
  alu_issue_if b ();
  alu_issue_stage dut (.clk(clk), .rst(rst), .bus(b));
  always #5 clk = ~clk;
  assign b.rf_rs1_data = rf[b.rf_rs1_addr];
  assign b.rf_rs2_data = rf[b.rf_rs2_addr];
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic step;
    @(posedge clk);
    #1;
  endtask
  function automatic logic [31:0] r_op(logic [6:0] f7, logic [4:0] rs2, logic [4:0] rs1, logic [2:0] f3, logic [4:0] rd);
    return {f7, rs2, rs1, f3, rd, 7'b0110011};
  endfunction
  function automatic logic [31:0] i_op(logic [11:0] imm, logic [4:0] rs1, logic [2:0] f3, logic [4:0] rd);
    return {imm, rs1, f3, rd, 7'b0010011};
  endfunction
  task automatic wb(input logic [4:0] r);
    b.in_valid = 1'b0;
    b.wb_valid = 1'b1;
    b.wb_rd = r;
    step;
    b.wb_valid = 1'b0;
  endtask
  initial begin
    for (int i = 0; i < 32; i++) rf[i] = 32'h100 + i;
    rf[0] = 32'd0;
    rf[1] = 32'd10;
    rf[2] = 32'd3;
    b.flush = 1'b0;
    b.in_valid = 1'b1;
    b.in_instr = r_op(7'b0, 5'd3, 5'd2, 3'b000, 5'd1);
    b.in_pc = 32'h0;
    b.out_ready = 1'b1;
    b.wb_valid = 1'b0;
    b.wb_rd = 5'd0;
    #1;
    chk("rst_in_ready", {31'b0, b.in_ready}, 32'd0);
    step;
    step;
    chk("rst_out_valid", {31'b0, b.out_valid}, 32'd0);
    chk("rst_in_ready2", {31'b0, b.in_ready}, 32'd0);
    chk("rst_opcode", {29'b0, b.alu_opcode}, 32'd0);
    chk("rst_ops", b.op_0 | b.op_1, 32'd0);
    chk("rst_rd", {27'b0, b.rd}, 32'd0);
    chk("rst_flags", {30'b0, b.rd_we, b.illegal}, 32'd0);
    rst = 1'b0;
    b.in_valid = 1'b0;
    step;
    // decode sweep
    b.in_valid = 1'b1;
    b.in_instr = r_op(7'b0100000, 5'd2, 5'd1, 3'b000, 5'd3);
    #1;
    chk("sub_in_ready", {31'b0, b.in_ready}, 32'd1);
    chk("sub_rs_addr", {22'b0, b.rf_rs1_addr, b.rf_rs2_addr}, {22'b0, 5'd1, 5'd2});
    step;
    chk("sub_valid", {31'b0, b.out_valid}, 32'd1);
    chk("sub_opcode", {29'b0, b.alu_opcode}, 32'd1);
    chk("sub_op_0", b.op_0, 32'd10);
    chk("sub_op_1", b.op_1, 32'd3);
    chk("sub_rd", {26'b0, b.rd_we, b.rd}, {26'b0, 1'b1, 5'd3});
    b.in_instr = i_op({7'b0100000, 5'd4}, 5'd6, 3'b101, 5'd5);
    step;
    chk("srai_opcode", {29'b0, b.alu_opcode}, 32'd7);
    chk("srai_op_0", b.op_0, 32'h106);
    chk("srai_op_1", b.op_1, 32'd4);
    b.in_instr = {20'h12345, 5'd7, 7'b0010111};
    b.in_pc = 32'h100;
    step;
    chk("auipc_opcode", {29'b0, b.alu_opcode}, 32'd0);
    chk("auipc_op_0", b.op_0, 32'h100);
    chk("auipc_op_1", b.op_1, 32'h12345000);
    chk("auipc_rd", {27'b0, b.rd}, 32'd7);
    wb(5'd3);
    chk("drain_valid", {31'b0, b.out_valid}, 32'd0);
    wb(5'd5);
    wb(5'd7);
    // RAW stall on x1
    b.in_valid = 1'b1;
    b.in_instr = i_op(12'd5, 5'd0, 3'b000, 5'd1);
    step;
    chk("addi_op_0", b.op_0, 32'd0);
    chk("addi_op_1", b.op_1, 32'd5);
    b.in_instr = r_op(7'b0, 5'd1, 5'd1, 3'b000, 5'd2);
    chk("raw_stall0", {31'b0, b.in_ready}, 32'd0);
    step;
    chk("raw_stall1", {31'b0, b.in_ready}, 32'd0);
    chk("raw_no_issue", {31'b0, b.out_valid}, 32'd0);
    b.wb_valid = 1'b1;
    b.wb_rd = 5'd1;
    #1;
    chk("raw_no_bypass", {31'b0, b.in_ready}, 32'd0);
    step;
    b.wb_valid = 1'b0;
    #1;
    chk("raw_release", {31'b0, b.in_ready}, 32'd1);
    step;
    chk("raw_issued", {26'b0, b.out_valid, b.rd}, {26'b0, 1'b1, 5'd2});
    chk("raw_op_0", b.op_0, 32'd10);
    wb(5'd2);
    // backpressure
    b.out_ready = 1'b0;
    b.in_valid = 1'b1;
    b.in_instr = r_op(7'b0, 5'd2, 5'd1, 3'b000, 5'd11);
    step;
    b.in_instr = r_op(7'b0, 5'd2, 5'd1, 3'b100, 5'd12);
    for (int i = 0; i < 4; i++) begin
      chk("bp_in_ready", {31'b0, b.in_ready}, 32'd0);
      chk("bp_hold", {26'b0, b.out_valid, b.rd}, {26'b0, 1'b1, 5'd11});
      step;
    end
    chk("bp_hold_ops", b.op_0 + b.op_1, 32'd13);
    b.out_ready = 1'b1;
    #1;
    chk("bp_ready", {31'b0, b.in_ready}, 32'd1);
    step;
    chk("bp_second", {24'b0, b.alu_opcode, b.rd}, {24'b0, 3'b100, 5'd12});
    b.in_instr = r_op(7'b0, 5'd2, 5'd1, 3'b110, 5'd13);
    step;
    chk("bp_third", {24'b0, b.alu_opcode, b.rd}, {24'b0, 3'b011, 5'd13});
    wb(5'd11);
    wb(5'd12);
    wb(5'd13);
    // illegal encodings
    b.in_valid = 1'b1;
    b.in_instr = r_op(7'b0, 5'd2, 5'd1, 3'b010, 5'd4);
    step;
    chk("slt_flags", {30'b0, b.illegal, b.rd_we}, {30'b0, 1'b1, 1'b0});
    chk("slt_zero", {29'b0, b.alu_opcode} | b.op_0 | b.op_1, 32'd0);
    b.in_instr = {25'h0, 7'b1111111} | 32'h200;
    step;
    chk("bad_opc", {30'b0, b.illegal, b.rd_we}, {30'b0, 1'b1, 1'b0});
    b.in_instr = r_op(7'b0000001, 5'd2, 5'd1, 3'b101, 5'd4);
    step;
    chk("bad_f7", {31'b0, b.illegal}, 32'd1);
    b.in_instr = r_op(7'b0, 5'd4, 5'd4, 3'b000, 5'd5);
    #1;
    chk("ill_no_pend", {31'b0, b.in_ready}, 32'd1);
    step;
    chk("ill_follow", {25'b0, b.illegal, b.out_valid, b.rd}, {25'b0, 1'b0, 1'b1, 5'd5});
    wb(5'd5);
    // flush of a held instruction
    b.out_ready = 1'b0;
    b.in_valid = 1'b1;
    b.in_instr = i_op(12'd1, 5'd0, 3'b000, 5'd9);
    step;
    chk("fl_held", {26'b0, b.out_valid, b.rd}, {26'b0, 1'b1, 5'd9});
    b.in_valid = 1'b0;
    b.flush = 1'b1;
    #1;
    chk("fl_in_ready", {31'b0, b.in_ready}, 32'd0);
    step;
    b.flush = 1'b0;
    chk("fl_out_valid", {31'b0, b.out_valid}, 32'd0);
    b.out_ready = 1'b1;
    b.in_valid = 1'b1;
    b.in_instr = r_op(7'b0, 5'd9, 5'd9, 3'b000, 5'd10);
    #1;
    chk("fl_cleared", {31'b0, b.in_ready}, 32'd1);
    step;
    chk("fl_follow", {26'b0, b.out_valid, b.rd}, {26'b0, 1'b1, 5'd10});
    chk("fl_follow_op", b.op_0, 32'h109);
    b.in_valid = 1'b0;
    step;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/alu_issue_stage.md
# alu_issue_stage

Decode-and-issue stage directly upstream of the ALU in the RV32I core. Accepts one instruction per cycle over a valid/ready handshake, decodes the ALU subset into the 3-bit ALU operation code, selects and registers both ALU operands, and holds them in an output register until the execute side takes them. A 31-entry pending-write scoreboard stalls issue on RAW/WAW hazards until writeback clears the destination.

## Interface
Parameters:
- none (XLEN fixed at 32, 32 architectural registers)

Ports:
- clk  in  1  sole clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- flush  in  1  synchronous; discards held output instruction
- in_valid  in  1  instruction/PC valid
- in_ready  out  1  stage accepts this cycle (combinational)
- in_instr  in  32  instruction word
- in_pc  in  32  instruction address
- rf_rs1_addr  out  5  = in_instr[19:15], combinational
- rf_rs2_addr  out  5  = in_instr[24:20], combinational
- rf_rs1_data  in  32  combinational register-file read data
- rf_rs2_data  in  32  combinational register-file read data
- out_valid  out  1  registered operands valid
- out_ready  in  1  execute side consumes this cycle
- alu_opcode  out  3  ADD=000 SUB=001 AND=010 OR=011 XOR=100 SLL=101 SRL=110 SRA=111
- op_0  out  32  ALU operand 0
- op_1  out  32  ALU operand 1
- rd  out  5  destination register
- rd_we  out  1  result is written back
- illegal  out  1  instruction outside supported subset
- wb_valid  in  1  writeback completes this cycle
- wb_rd  in  5  register being written back

## Operation
- Supported decode (opcode in_instr[6:0]):
  - OP 0110011: funct3/funct7 ADD, SUB(f7=0100000), SLL, XOR, SRL, SRA(f7=0100000), OR, AND; op_0=rs1 data, op_1=rs2 data.
  - OP-IMM 0010011: ADDI, XORI, ORI, ANDI (op_1 = sign-extended imm[31:20]); SLLI/SRLI/SRAI, op_1 = zero-extended shamt in_instr[24:20], SRAI when in_instr[31:25]=0100000.
  - LUI 0110111: ADD, op_0=0, op_1={in_instr[31:12],12'b0}.
  - AUIPC 0010111: ADD, op_0=in_pc, op_1={in_instr[31:12],12'b0}.
- Illegal: any other opcode; SLT/SLTU/SLTI/SLTIU; OP funct7 not 0000000/0100000, or 0100000 with funct3 other than ADD/SRL; shift-imm in_instr[31:25] not 0000000/0100000. Illegal instructions issue with illegal=1, rd_we=0, alu_opcode=000, op_0=op_1=0, no source hazard check, no scoreboard update.
- rd_we=1 for legal instructions with rd≠0; rd=in_instr[11:7] always.
- Scoreboard: 31 bits (x1..x31); x0 never pending.
  - Set bit rd on accept of a legal instruction with rd_we=1.
  - Clear bit wb_rd on wb_valid (wb_rd=0 ignored).
  - Same register set and cleared in one cycle: set wins.
- Hazard: stall if any used source (rs1 for OP/OP-IMM, rs2 for OP) or rd (when rd_we) has its pending bit set. Uses registered bits only; no bypass from wb in the same cycle.
- in_ready = !rst && !flush && !hazard && (!out_valid || out_ready).
- Accept = in_valid && in_ready; output register loads all fields and out_valid=1.
- out_valid clears when out_ready && !accept.
- Flush: out_valid←0; if out_valid was 1 and held rd_we=1, clear held rd's pending bit (unless wb sets nothing — clear is unconditional). Other pending bits unaffected. No accept in the flush cycle.

## Timing
- Reset values: out_valid=0, alu_opcode=000, op_0=op_1=0, rd=0, rd_we=0, illegal=0, scoreboard all 0; in_ready=0 during rst.
- Latency: accept in cycle N → fields on outputs, out_valid=1 from cycle N+1.
- Throughput 1/cycle with out_ready held high and no hazards.
- Outputs stable while out_valid && !out_ready.
- Writeback in cycle N clears bit at edge N; dependent instruction accepted no earlier than cycle N+1.
- Reset mid-operation: all state cleared at the next edge regardless of handshake.

## Test plan
- Reset: assert rst 2 cycles with in_valid=1 → out_valid=0, in_ready=0, all outputs 0, scoreboard empty.
- Decode sweep: SUB x3,x1,x2 with rf data 10/3 → alu_opcode=001, op_0=10, op_1=3, rd=3; SRAI x5,x6,4 → 111, op_1=4; AUIPC x7,0x12345 at pc 0x100 → 000, op_0=0x100, op_1=0x12345000.
- RAW stall: ADDI x1,x0,5 then ADD x2,x1,x1 → second held (in_ready=0) until wb_valid,wb_rd=1; accepted the cycle after.
- Backpressure: 3 back-to-back legal instructions, out_ready=0 for 4 cycles → first held stable, in_ready=0; then 1/cycle drain in order.
- Illegal: SLT x4,x1,x2 and opcode 1111111 → illegal=1, rd_we=0, bit x4 not set; following ADD x5,x4,x4 issues without stall.
- Flush: held ADDI x9 with out_valid=1, pulse flush → out_valid=0 next cycle, bit x9 cleared; subsequent ADD x10,x9,x9 accepted immediately.
